snake_dir_scheduler: RTL and testbench
======================================

Name: snake_dir_scheduler

Overview:
- Sits between the PS/2 key-press driver and the snake game-step logic.
- Accepts W/A/S/D make codes and turns them into 2-bit direction commands.
- Rejects duplicate, reversing and overflow presses, and buffers the legal ones in a small FIFO.
- Releases one direction per game tick, so fast key bursts are neither lost nor applied mid-step.

Parameters:
- QDEPTH, 4: number of buffered direction commands. Must be a power of 2 and at least 2.
- CW, $clog2(QDEPTH+1): width of the occupancy count. Derived; do not override.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle pulse from the driver when a new code is available.
- make_break  in  1  1 = make (press), 0 = break (release). Break codes are ignored.
- key_code  in  8  PS/2 scan code, sampled only when key_valid=1.
- tick  in  1  one-cycle game-step pulse.
- dir  out  2  current applied direction: 00 up, 01 right, 10 down, 11 left.
- dir_update  out  1  one-cycle pulse; dir holds the value for the new step.
- queue_count  out  CW  number of buffered commands.
- dropped  out  1  one-cycle pulse; a legal-code make press was rejected.
- paused  out  1  pause state. Tied 0 when PAUSE_KEY_EN is not defined.

Behaviour:
- Reset: all state is cleared on a clk edge with reset_n=0.
  - dir=01, dir_update=0, queue_count=0, dropped=0, paused=0.
  - FIFO pointers are zeroed. Reset mid-burst discards queued entries.
- Decode (combinational): 1D->00, 23->01, 1B->10, 1C->11. Any other code is "not a direction".
- Accept event: key_valid=1 & make_break=1 & code is a direction.
  - Events with key_valid=1 and any other code are ignored silently; no dropped pulse.
- Reference direction: the FIFO tail entry if queue_count>0 before the edge, else dir.
- Reject an accept event, pulse dropped next cycle and leave the FIFO unchanged, when any of these holds:
  - new == reference (duplicate).
  - new is the reverse of reference: new[0]==ref[0] & new[1]!=ref[1].
  - the FIFO is full and no pop happens in the same cycle.
- Otherwise push at the tail and increment queue_count.
- Tick, at the edge where tick=1:
  - dir_update=1 on the following cycle, with exactly one cycle of latency.
  - If queue_count>0, pop the head into dir and decrement queue_count.
  - If empty, dir is unchanged; dir_update still pulses, so the game steps in the current direction.
- Tick and accept in the same cycle:
  - Pop and push both occur and queue_count is net unchanged.
  - A push into a full queue is allowed in this case.
  - The reference used is the pre-edge tail (empty -> pre-edge dir).
- Pointers wrap modulo QDEPTH. queue_count never exceeds QDEPTH and never underflows.
- Outputs: dir, dir_update, dropped and paused are registered. queue_count is derived from registered state only.

Optional Feature:
- Macro: PAUSE_KEY_EN.
- Defined:
  - A make of code 29 (space) toggles paused.
  - While paused=1, tick is ignored: no pop and no dir_update.
  - Direction keys are still filtered and queued normally.
  - Break of 29 has no effect. Reset clears paused.
- Not defined:
  - Code 29 is treated as a non-direction and ignored.
  - paused is tied to 0 and all tick behaviour is as above.

Test Plan:
- Reset, then 3 ticks with no keys -> dir=01 on all three steps, dir_update pulses 3 times, queue_count=0.
- Make 1D, make 1B, tick, tick -> 1D accepted (count=1); 1B rejected as reverse of tail 00 (dropped pulse). Tick1 gives dir=00, tick2 gives dir=00.
- Make 1D, 1C, 1B, 23, 1D with QDEPTH=4, then 5 ticks:
  - First four accepted; the fifth is dropped (full, no pop).
  - Ticks yield dir 00, 11, 10, 01, 01.
- Queue full, then tick and make 1B in the same cycle -> count stays 4, head popped to dir, no dropped pulse.
- Make 23 with dir=01 and queue empty -> dropped (duplicate). Break of 1D and make of 2A -> no queue change, no dropped pulse.
- PAUSE_KEY_EN: make 29, then 2 ticks -> paused=1, no dir_update. Make 29 again, then tick -> paused=0, dir_update pulses.

Source files
------------

// File: rtl/snake_dir_scheduler.sv
// snake_dir_scheduler: filters W/A/S/D make codes into 2-bit direction
// commands, queues the legal ones and releases one per game tick.
// Optional build macro: PAUSE_KEY_EN (space make toggles a tick-freezing pause).
module snake_dir_scheduler #(
    parameter int QDEPTH = 4,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          key_valid,
    input  logic          make_break,
    input  logic [7:0]    key_code,
    input  logic          tick,
    output logic [1:0]    dir,
    output logic          dir_update,
    output logic [CW-1:0] queue_count,
    output logic          dropped,
    output logic          paused
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [1:0]    r_fifo [QDEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_dir;
    logic          r_dir_update;
    logic          r_dropped;

    logic          w_is_dir;
    logic [1:0]    w_new;
    logic          w_accept;
    logic [PW-1:0] w_tail_ptr;
    logic [1:0]    w_ref;
    logic          w_nonempty, w_full;
    logic          w_tick, w_pop, w_reject, w_push;

    // Scan code to direction: W=up, D=right, S=down, A=left
    always_comb begin
        w_is_dir = 1'b1;
        w_new    = 2'b00;
        case (key_code)
            8'h1D:   w_new = 2'b00;
            8'h23:   w_new = 2'b01;
            8'h1B:   w_new = 2'b10;
            8'h1C:   w_new = 2'b11;
            default: w_is_dir = 1'b0;
        endcase
    end

`ifdef PAUSE_KEY_EN
    logic r_paused;
    logic w_pause_key;
    assign w_pause_key = key_valid & make_break & (key_code == 8'h29);
    // Space make toggles pause; ticks are frozen while paused
    always_ff @(posedge clk) begin
        if (!reset_n)        r_paused <= 1'b0;
        else if (w_pause_key) r_paused <= ~r_paused;
    end
    assign w_tick = tick & ~r_paused;
    assign paused = r_paused;
`else
    assign w_tick = tick;
    assign paused = 1'b0;
`endif

    assign w_accept   = key_valid & make_break & w_is_dir;
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(QDEPTH));
    assign w_tail_ptr = r_wr_ptr - PW'(1);
    // New presses are judged against the last queued move, not the live one,
    // so a queued burst cannot contain a 180-degree turn
    assign w_ref      = w_nonempty ? r_fifo[w_tail_ptr] : r_dir;
    assign w_pop      = w_tick & w_nonempty;
    assign w_reject   = w_accept & ((w_new == w_ref) ||
                                    ((w_new[0] == w_ref[0]) && (w_new[1] != w_ref[1])) ||
                                    (w_full && !w_pop));
    assign w_push     = w_accept & ~w_reject;

    // FIFO storage; contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_new;
    end

    // Pointers, occupancy, applied direction and output pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dir        <= 2'b01;
            r_dir_update <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_dir    <= r_fifo[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_dir_update <= w_tick;
            r_dropped    <= w_reject;
        end
    end

    assign dir         = r_dir;
    assign dir_update  = r_dir_update;
    assign dropped     = r_dropped;
    assign queue_count = r_count;
endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Scoreboard bench for snake_dir_scheduler: a queue-based model of the
// direction buffer predicts each dir_update / dropped pulse; a monitor
// pops and compares whenever the DUT pulses.
module tb_snake_dir_scheduler;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          key_valid, make_break, tick;
    logic [7:0]    key_code;
    logic [1:0]    dir;
    logic          dir_update, dropped, paused;
    logic [CW-1:0] queue_count;

    snake_dir_scheduler #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .make_break(make_break),
        .key_code(key_code), .tick(tick), .dir(dir), .dir_update(dir_update),
        .queue_count(queue_count), .dropped(dropped), .paused(paused)
    );

    always #10 clk = ~clk;

    typedef struct { int cyc; logic [1:0] d; } exp_t;
    exp_t       exp_upd_q[$];
    int         exp_drop_q[$];
    logic [1:0] mq[$];
    logic [1:0] m_dir = 2'd1;
    bit         m_paused = 1'b0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         checks = 0, errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit dec(input logic [7:0] c, output logic [1:0] d);
        d = 2'd0;
        case (c)
            8'h1D: d = 2'd0;
            8'h23: d = 2'd1;
            8'h1B: d = 2'd2;
            8'h1C: d = 2'd3;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One clock of stimulus; model state is committed after the edge
    task automatic step(input bit kv, input bit mb, input logic [7:0] code, input bit tk);
        logic [1:0] nd, rf, nxt_dir;
        logic [1:0] nq[$];
        bit isd, acc, tk_eff, np;
        int n;
        exp_t e;
        key_valid = kv; make_break = mb; key_code = code; tick = tk;
        nq = mq;
        n = mq.size();
        nxt_dir = m_dir;
        np = m_paused;
        isd = dec(code, nd);
        acc = kv && mb && isd;
        rf = (n > 0) ? mq[n-1] : m_dir;
        tk_eff = tk && !m_paused;
`ifdef PAUSE_KEY_EN
        if (kv && mb && code == 8'h29) np = !m_paused;
`endif
        if (tk_eff) begin
            if (n > 0) nxt_dir = nq.pop_front();
            e.cyc = cyc + 1; e.d = nxt_dir;
            exp_upd_q.push_back(e);
        end
        if (acc) begin
            // opposite direction is two steps round the compass
            if (nd == rf || nd == 2'(rf + 2) || (n == QDEPTH && !(tk_eff && n > 0)))
                exp_drop_q.push_back(cyc + 1);
            else
                nq.push_back(nd);
        end
        @(posedge clk); #1;
        mq = nq; m_dir = nxt_dir; m_paused = np;
        key_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; key_valid = 1'b0; make_break = 1'b0; key_code = 8'h00; tick = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mq.delete(); m_dir = 2'd1; m_paused = 1'b0;
    endtask

    // Monitor: continuous state checks plus scoreboard pops on each pulse
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dir", dir, m_dir);
            chk("queue_count", queue_count, mq.size());
            chk("paused", paused, m_paused);
            while (exp_upd_q.size() > 0 && exp_upd_q[0].cyc < cyc) begin
                chk("dir_update_missing", 0, 1);
                void'(exp_upd_q.pop_front());
            end
            while (exp_drop_q.size() > 0 && exp_drop_q[0] < cyc) begin
                chk("dropped_missing", 0, 1);
                void'(exp_drop_q.pop_front());
            end
            if (dir_update) begin
                if (exp_upd_q.size() == 0) chk("dir_update_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = exp_upd_q.pop_front();
                    chk("dir_update_cycle", cyc, e.cyc);
                    chk("dir_update_dir", dir, e.d);
                end
            end
            if (dropped) begin
                if (exp_drop_q.size() == 0) chk("dropped_unexpected", 1, 0);
                else chk("dropped_cycle", cyc, exp_drop_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] codes [8];
        codes[0] = 8'h1D; codes[1] = 8'h23; codes[2] = 8'h1B; codes[3] = 8'h1C;
        codes[4] = 8'h29; codes[5] = 8'h2A; codes[6] = 8'h1D; codes[7] = 8'h00;
        reset_n = 1'b0; key_valid = 1'b0; make_break = 1'b0; key_code = 8'h00; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        chk("reset_dir", dir, 1);
        chk("reset_dir_update", dir_update, 0);
        chk("reset_count", queue_count, 0);
        chk("reset_dropped", dropped, 0);
        chk("reset_paused", paused, 0);

        // idle ticks step in the reset direction
        repeat (3) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // up accepted, down rejected as reverse of queued up
        do_reset();
        step(1, 1, 8'h1D, 0);
        chk("one_queued", queue_count, 1);
        step(1, 1, 8'h1B, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        chk("dir_after_up", dir, 0);

        // burst overflows the 4-deep queue
        do_reset();
        step(1, 1, 8'h1D, 0); step(1, 1, 8'h1C, 0);
        step(1, 1, 8'h1B, 0); step(1, 1, 8'h23, 0);
        chk("burst_full", queue_count, QDEPTH);
        step(1, 1, 8'h1D, 0);
        repeat (5) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // push into full queue alongside a pop
        do_reset();
        step(1, 1, 8'h1D, 0); step(1, 1, 8'h1C, 0);
        step(1, 1, 8'h1B, 0); step(1, 1, 8'h23, 0);
        step(1, 1, 8'h1B, 1);
        chk("full_pop_push_count", queue_count, QDEPTH);
        chk("full_pop_push_dir", dir, 0);
        step(0, 0, 8'h00, 0);

        // duplicate, break and non-direction codes
        do_reset();
        step(1, 1, 8'h23, 0);
        step(1, 0, 8'h1D, 0);
        step(1, 1, 8'h2A, 0);
        step(0, 0, 8'h00, 0);
        chk("ignored_count", queue_count, 0);

`ifdef PAUSE_KEY_EN
        do_reset();
        step(1, 1, 8'h29, 0);
        step(0, 0, 8'h00, 1); step(0, 0, 8'h00, 1);
        chk("pause_on", paused, 1);
        step(1, 1, 8'h29, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        chk("pause_off", paused, 0);
`endif

        // randomized traffic with occasional mid-burst resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                      (i % 17 == 0) ? 8'($urandom) : codes[$urandom_range(0, 7)],
                      $urandom_range(0, 3) == 0);
        end
        repeat (3) step(0, 0, 8'h00, 0);
        chk("pending_updates", exp_upd_q.size(), 0);
        chk("pending_drops", exp_drop_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
